multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle MIPS control unit: a Moore FSM that sequences fetch/decode/execute
//  over several clocks and shares one ALU and one memory port. Successor to the
//  single-cycle decoder. Adds memory wait-states, a watchdog timeout and an
//  illegal-instruction trap. Sits between the instruction register and the datapath.
// PARAMETERS
//  ALU_W    3   alucontrol width; codes zero-extended: add=2 sub=6 and=0 or=1 slt=7
//  TIMEOUT  0   max consecutive mem_ready=0 cycles in a wait state; 0 = wait forever
//  CNT_W    8   watchdog counter width; must satisfy TIMEOUT < 2**CNT_W
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      async active-low reset
//  op          in   6      IR[31:26]
//  funct       in   6      IR[5:0]
//  zero        in   1      ALU zero flag
//  mem_ready   in   1      memory completes the access this cycle
//  pcen        out  1      PC load = pcwrite | (branch & zero) [| bne & ~zero]
//  iord        out  1      0 = PC addresses memory, 1 = ALUOut
//  memwrite    out  1      memory write strobe
//  irwrite     out  1      IR load
//  regdst      out  1      1 = rd, 0 = rt
//  memtoreg    out  1      1 = MDR to register file
//  regwrite    out  1      register-file write
//  alusrca     out  1      0 = PC, 1 = rs
//  alusrcb     out  2      00 rt, 01 const 4, 10 signimm, 11 signimm<<2
//  pcsrc       out  2      00 ALU result, 01 ALUOut, 10 jump target
//  alucontrol  out  ALU_W  ALU operation
//  zext        out  1      immediate zero-extend select
//  illegal     out  1      high while in FAULT
//  state_o     out  4      current state encoding (debug)
// BEHAVIOUR
//  - States (encoding): FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 EXEC6 ALUWB7
//    BRANCH8 ADDIEX9 ADDIWB10 JUMP11 FAULT15. Register state; outputs decode state.
//  - Reset (rst_n=0, async): state=FETCH, watchdog=0. All enables forced 0 while
//    rst_n is low. Reset mid-instruction aborts it; no partial write after release.
//  - Every output not listed for a state is 0; alucontrol defaults to add.
//  - FETCH: alusrcb=01, iord=0. irwrite=pcwrite=1 only in a cycle with mem_ready=1,
//    then -> DECODE. Otherwise hold FETCH.
//  - DECODE: alusrcb=11 (branch target). lw/sw->MEMADR, R->EXEC, beq(000100)->BRANCH,
//    addi(001000)->ADDIEX, j(000010)->JUMP. Any other op, or R-type funct not in
//    {add,sub,and,or,slt}, -> FAULT.
//  - MEMADR: alusrca=1, alusrcb=10. lw->MEMRD, sw->MEMWR.
//  - MEMRD: iord=1; hold until mem_ready, then -> MEMWB.
//  - MEMWB: memtoreg=1, regwrite=1 -> FETCH.
//  - MEMWR: iord=1, memwrite=1 held until mem_ready, then -> FETCH.
//  - EXEC: alusrca=1, alucontrol from funct -> ALUWB. ALUWB: regdst=1, regwrite=1 -> FETCH.
//  - BRANCH: alusrca=1, sub, branch=1, pcsrc=01 -> FETCH.
//  - ADDIEX: alusrca=1, alusrcb=10, add -> ADDIWB. ADDIWB: regwrite=1 -> FETCH.
//  - JUMP: pcsrc=10, pcwrite=1 -> FETCH.
//  - FAULT: illegal=1, all enables 0. Sticky until reset.
//  - Min latency with zero wait: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles.
//  - Watchdog: counts consecutive mem_ready=0 cycles in FETCH/MEMRD/MEMWR. Clears on
//    state change or mem_ready=1. TIMEOUT>0 and count==TIMEOUT with mem_ready=0 ->
//    FAULT next edge. mem_ready=1 in that same cycle wins: normal transition.
//    Counter saturates, never wraps.
// CONFIGURATION
//  MCU_EXT_OPS_EN defined: adds bne(000101)->BRANCH with pcen=~zero, and
//    andi(001100)/ori(001101)->ADDIEX with zext=1 and alucontrol and/or.
//  Macro undefined: these opcodes -> FAULT, and zext is tied 0.
// TESTING
//  - Reset then lw, mem_ready always 1 -> states 0,1,2,3,4,0; regwrite=1 only in MEMWB.
//  - sw with mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH.
//  - beq with zero=1 -> pcen=1 in BRANCH. With zero=0 -> pcen=0; back to FETCH both ways.
//  - op=111111 -> FAULT, illegal=1, held 10 cycles; rst_n pulse -> FETCH, illegal=0.
//  - TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 4 idle cycles.
//    Same, but mem_ready=1 on cycle 4 -> DECODE.
//  - MCU_EXT_OPS_EN: ori -> zext=1, alucontrol=1 in ADDIEX. Without macro, ori -> FAULT.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: multi-cycle MIPS control FSM with memory wait-states, watchdog and illegal-op trap; define MCU_EXT_OPS_EN to add bne/andi/ori
module multicycle_ctrl_fsm #(
  parameter int ALU_W   = 3,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcen,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [ALU_W-1:0] alucontrol,
  output logic             zext,
  output logic             illegal,
  output logic [3:0]       state_o
);
`ifdef MCU_EXT_OPS_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif
  localparam logic [ALU_W-1:0] A_AND = ALU_W'(0);
  localparam logic [ALU_W-1:0] A_OR  = ALU_W'(1);
  localparam logic [ALU_W-1:0] A_ADD = ALU_W'(2);
  localparam logic [ALU_W-1:0] A_SUB = ALU_W'(6);
  localparam logic [ALU_W-1:0] A_SLT = ALU_W'(7);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11,
    FAULT = 4'd15
  } state_t;
  state_t state, nxt, dec_nxt;
  logic [CNT_W-1:0] cnt;
  logic pcw_q, br_q, bne_q;
  logic is_r, is_mem, is_br, is_imm, ext_i, r_ok, wait_st, timeout;
  logic [ALU_W-1:0] alu_f, alu_i;
  assign is_r    = op == 6'b000000;
  assign is_mem  = op == 6'b100011 || op == 6'b101011;
  assign is_br   = op == 6'b000100 || (EXT && op == 6'b000101);
  assign ext_i   = EXT && (op == 6'b001100 || op == 6'b001101);
  assign is_imm  = op == 6'b001000 || ext_i;
  assign r_ok    = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  assign alu_f   = funct == 6'b100010 ? A_SUB : funct == 6'b100100 ? A_AND :
                   funct == 6'b100101 ? A_OR : funct == 6'b101010 ? A_SLT : A_ADD;
  assign alu_i   = !ext_i ? A_ADD : op == 6'b001100 ? A_AND : A_OR;
  assign dec_nxt = is_r ? (r_ok ? EXEC : FAULT) : is_mem ? MEMADR : is_br ? BRANCH :
                   is_imm ? ADDIEX : op == 6'b000010 ? JUMP : FAULT;
  assign wait_st = state == FETCH || state == MEMRD || state == MEMWR;
  assign timeout = TIMEOUT != 0 && wait_st && !mem_ready && cnt == CNT_W'(TIMEOUT);
  assign irwrite = rst_n && state == FETCH && mem_ready;
  assign pcen    = irwrite || pcw_q || (br_q && (bne_q ? !zero : zero));
  assign state_o = state;
  // next-state selection; wait states stall on mem_ready and trap on watchdog expiry
  always_comb begin
    nxt = FAULT;
    case (state)
      FETCH:  nxt = timeout ? FAULT : mem_ready ? DECODE : FETCH;
      DECODE: nxt = dec_nxt;
      MEMADR: nxt = op == 6'b101011 ? MEMWR : MEMRD;
      MEMRD:  nxt = timeout ? FAULT : mem_ready ? MEMWB : MEMRD;
      MEMWR:  nxt = timeout ? FAULT : mem_ready ? FETCH : MEMWR;
      EXEC:   nxt = ALUWB;
      ADDIEX: nxt = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: nxt = FETCH;
      default: nxt = FAULT;
    endcase
  end
  // state, watchdog and outputs decoded from the next state all load on the same edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= FETCH;
      cnt        <= '0;
      iord       <= 1'b0;
      memwrite   <= 1'b0;
      regdst     <= 1'b0;
      memtoreg   <= 1'b0;
      regwrite   <= 1'b0;
      alusrca    <= 1'b0;
      alusrcb    <= 2'b01;
      pcsrc      <= 2'b00;
      alucontrol <= A_ADD;
      zext       <= 1'b0;
      illegal    <= 1'b0;
      pcw_q      <= 1'b0;
      br_q       <= 1'b0;
      bne_q      <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= (nxt != state || mem_ready || !wait_st) ? '0 : cnt == '1 ? cnt : cnt + 1'b1;
      iord       <= nxt == MEMRD || nxt == MEMWR;
      memwrite   <= nxt == MEMWR;
      regdst     <= nxt == ALUWB;
      memtoreg   <= nxt == MEMWB;
      regwrite   <= nxt == MEMWB || nxt == ALUWB || nxt == ADDIWB;
      alusrca    <= nxt == MEMADR || nxt == EXEC || nxt == BRANCH || nxt == ADDIEX;
      alusrcb    <= nxt == FETCH ? 2'b01 : nxt == DECODE ? 2'b11 :
                    (nxt == MEMADR || nxt == ADDIEX) ? 2'b10 : 2'b00;
      pcsrc      <= nxt == BRANCH ? 2'b01 : nxt == JUMP ? 2'b10 : 2'b00;
      alucontrol <= nxt == EXEC ? alu_f : nxt == BRANCH ? A_SUB : nxt == ADDIEX ? alu_i : A_ADD;
      zext       <= nxt == ADDIEX && ext_i;
      illegal    <= nxt == FAULT;
      pcw_q      <= nxt == JUMP;
      br_q       <= nxt == BRANCH;
      bne_q      <= EXT && op == 6'b000101;
    end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: scoreboard bench for multicycle_ctrl_fsm (TIMEOUT=4); honours MCU_EXT_OPS_EN
module tb_multicycle_ctrl_fsm;
  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] op = 6'b100011, funct = 6'b100000;
  logic pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, zext, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state_o;
  logic [16:0] outs;
  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [16:0] o;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;

  // {pcen,iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,zext,illegal}
  localparam logic [16:0] O_FETCH = 17'h00088, O_FETCH_GO = 17'h12088, O_DEC = 17'h00188;
  localparam logic [16:0] O_MADR = 17'h00308, O_MRD = 17'h08008, O_MWB = 17'h00C08;
  localparam logic [16:0] O_MWR = 17'h0C008, O_EX_ADD = 17'h00208, O_EX_SUB = 17'h00218;
  localparam logic [16:0] O_EX_SLT = 17'h0021C, O_ALUWB = 17'h01408, O_BR_T = 17'h10238;
  localparam logic [16:0] O_BR_N = 17'h00238, O_ADDIEX = 17'h00308, O_ADDIWB = 17'h00408;
  localparam logic [16:0] O_JUMP = 17'h10048, O_FAULT = 17'h00009, O_ORIEX = 17'h00306;

  multicycle_ctrl_fsm #(.ALU_W(3), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .zext(zext), .illegal(illegal), .state_o(state_o)
  );

  assign outs = {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, alucontrol, zext, illegal};

  always #5 clk = ~clk;

  // monitor: pops one expectation per cycle, mid-cycle
  always @(negedge clk)
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (state_o !== e.st || outs !== e.o) begin
        bad++;
        $display("FAIL %s: got state=%0d outs=%h, want state=%0d outs=%h",
                 e.name, state_o, outs, e.st, e.o);
      end
    end

  task automatic cyc(input string n, input logic mr, input logic z, input logic [3:0] st,
                     input logic [16:0] o);
    exp_t e;
    mem_ready = mr;
    zero = z;
    e.name = n;
    e.st = st;
    e.o = o;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input string n);
    rst_n = 1'b0;
    cyc(n, 1'b1, 1'b1, 4'd0, O_FETCH);
    rst_n = 1'b1;
  endtask

  task automatic instr(input logic [5:0] o, input logic [5:0] f);
    op = o;
    funct = f;
    cyc("fetch", 1'b1, 1'b0, 4'd0, O_FETCH_GO);
    cyc("decode", 1'b1, 1'b0, 4'd1, O_DEC);
  endtask

  initial begin
    @(posedge clk);
    #1;
    cyc("reset0", 1'b1, 1'b1, 4'd0, O_FETCH);
    cyc("reset1", 1'b1, 1'b1, 4'd0, O_FETCH);
    rst_n = 1'b1;
    instr(6'b100011, 6'b0);
    cyc("lw_madr", 1'b1, 1'b0, 4'd2, O_MADR);
    cyc("lw_mrd", 1'b1, 1'b0, 4'd3, O_MRD);
    cyc("lw_mwb", 1'b1, 1'b0, 4'd4, O_MWB);
    instr(6'b101011, 6'b0);
    cyc("sw_madr", 1'b1, 1'b0, 4'd2, O_MADR);
    for (int i = 0; i < 3; i++) cyc("sw_wait", 1'b0, 1'b0, 4'd5, O_MWR);
    cyc("sw_done", 1'b1, 1'b0, 4'd5, O_MWR);
    instr(6'b000000, 6'b100000);
    cyc("add_ex", 1'b1, 1'b0, 4'd6, O_EX_ADD);
    cyc("add_wb", 1'b1, 1'b0, 4'd7, O_ALUWB);
    instr(6'b000000, 6'b100010);
    cyc("sub_ex", 1'b1, 1'b0, 4'd6, O_EX_SUB);
    cyc("sub_wb", 1'b1, 1'b0, 4'd7, O_ALUWB);
    instr(6'b000000, 6'b101010);
    cyc("slt_ex", 1'b1, 1'b0, 4'd6, O_EX_SLT);
    cyc("slt_wb", 1'b1, 1'b0, 4'd7, O_ALUWB);
    instr(6'b000100, 6'b0);
    cyc("beq_taken", 1'b1, 1'b1, 4'd8, O_BR_T);
    instr(6'b000100, 6'b0);
    cyc("beq_not", 1'b1, 1'b0, 4'd8, O_BR_N);
    instr(6'b001000, 6'b0);
    cyc("addi_ex", 1'b1, 1'b0, 4'd9, O_ADDIEX);
    cyc("addi_wb", 1'b1, 1'b0, 4'd10, O_ADDIWB);
    instr(6'b000010, 6'b0);
    cyc("jump", 1'b1, 1'b0, 4'd11, O_JUMP);
    instr(6'b001101, 6'b0);
`ifdef MCU_EXT_OPS_EN
    cyc("ori_ex", 1'b1, 1'b0, 4'd9, O_ORIEX);
    cyc("ori_wb", 1'b1, 1'b0, 4'd10, O_ADDIWB);
    cyc("ori_back", 1'b1, 1'b0, 4'd0, O_FETCH_GO);
`else
    cyc("ori_fault", 1'b1, 1'b0, 4'd15, O_FAULT);
`endif
    pulse_reset("rst_after_ori");
    instr(6'b000000, 6'b000000);
    cyc("badfunct", 1'b1, 1'b0, 4'd15, O_FAULT);
    pulse_reset("rst_after_badfunct");
    instr(6'b111111, 6'b0);
    for (int i = 0; i < 10; i++) cyc("fault_hold", 1'b1, 1'b1, 4'd15, O_FAULT);
    pulse_reset("rst_clears_fault");
    for (int i = 0; i < 5; i++) cyc("wd_idle", 1'b0, 1'b0, 4'd0, O_FETCH);
    cyc("wd_fault", 1'b0, 1'b0, 4'd15, O_FAULT);
    pulse_reset("rst_after_wd");
    op = 6'b001000;
    for (int i = 0; i < 4; i++) cyc("wd_idle2", 1'b0, 1'b0, 4'd0, O_FETCH);
    cyc("wd_ready_wins", 1'b1, 1'b0, 4'd0, O_FETCH_GO);
    cyc("wd_decode", 1'b1, 1'b0, 4'd1, O_DEC);
    cyc("wd_addi_ex", 1'b1, 1'b0, 4'd9, O_ADDIEX);
    cyc("wd_addi_wb", 1'b1, 1'b0, 4'd10, O_ADDIWB);
    instr(6'b101011, 6'b0);
    cyc("abort_madr", 1'b1, 1'b0, 4'd2, O_MADR);
    cyc("abort_mwr", 1'b0, 1'b0, 4'd5, O_MWR);
    rst_n = 1'b0;
    cyc("abort_rst", 1'b0, 1'b0, 4'd0, O_FETCH);
    rst_n = 1'b1;
    cyc("abort_after", 1'b0, 1'b0, 4'd0, O_FETCH);
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish before 200000");
    $fatal(1, "bench timeout");
  end
endmodule
